// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster master. Divides the system clock down to the
// pixel rate, runs the horizontal/vertical counters, publishes the current
// coordinates to the pixel generators and drives registered, blanked RGB and
// active-low sync pins that lag the counters by exactly one pixel tick.
module vga_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A one-bit divider still exists when CLK_DIV is 1; it simply never leaves 0.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;

    // Only the top nibble of each colour channel reaches the 4-bit DAC pins.
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^{pixel_data[19:16], pixel_data[11:8], pixel_data[3:0]};

    assign pix_tick    = (div_cnt_q == DIV_LAST);
    assign video_on    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign frame_start = pix_tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    // Coordinates go out unmasked, even during blanking.
    assign pos_x = h_cnt_q;
    assign pos_y = v_cnt_q;

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;

    // Next state for the divider, raster counters and the pin register inputs.
    always_comb begin
        div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        // Sync and colour are decoded from the same counter values so the
        // pins stay mutually aligned one tick behind the counters.
        hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        rgb_d   = video_on ? {pixel_data[23:20], pixel_data[15:12], pixel_data[7:4]}
                           : 12'h000;
    end

    // State update; reset wins over a coincident tick and drops sync high at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= 12'h000;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            if (pix_tick) begin
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                rgb_q   <= rgb_d;
            end
        end
    end

endmodule
